lfsr_rand_gen: RTL and testbench

//   Parametrised Fibonacci LFSR pseudo-random word source for the VGA/GPU pipeline (noise, dither, sprite jitter).

---
 rtl/gpu_rand_pkg.sv | 28 ++
 rtl/lfsr_unroll.sv | 24 ++
 rtl/lfsr_rand_gen.sv | 97 +++++++++
 tb/tb_lfsr_rand_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rand_pkg.sv
// Shared constants and the single-shift helper for the GPU pseudo-random sources.
// Each mask has its top bit set, and each seed is nonzero so the register can never lock up at zero.
package gpu_rand_pkg;

    localparam int MAX_LFSR_W = 64;

    localparam logic [7:0]  GPU_RAND_MASK8  = 8'hB8;
    localparam logic [15:0] GPU_RAND_MASK16 = 16'hD008;
    localparam logic [31:0] GPU_RAND_MASK32 = 32'h8020_0003;
    localparam logic [47:0] GPU_RAND_MASK48 = 48'hC000_0030_0000;

    localparam logic [7:0]  GPU_RAND_SEED8  = 8'h5A;
    localparam logic [15:0] GPU_RAND_SEED16 = 16'hACE1;
    localparam logic [31:0] GPU_RAND_SEED32 = 32'h1234_5678;
    localparam logic [47:0] GPU_RAND_SEED48 = 48'h1234_5678_9ABC;

    // Bits above the caller's width are zero in the mask, so they never reach the feedback.
    // The caller keeps only the low bits of the result.
    function automatic logic [MAX_LFSR_W-1:0] lfsr_step(
        input logic [MAX_LFSR_W-1:0] state,
        input logic [MAX_LFSR_W-1:0] mask
    );
        logic fb;
        fb = ^(state & mask);
        return {state[MAX_LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_unroll.sv
// Combinational Fibonacci LFSR advance.
// Returns the state reached after STEP single-bit shifts.
module lfsr_unroll
    import gpu_rand_pkg::*;
#(
    parameter int                LFSR_W   = 48,
    parameter int                STEP     = 12,
    parameter logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(GPU_RAND_MASK48)
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] chain [0:STEP];

    assign chain[0] = state_i;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_shift
        assign chain[gi+1] = LFSR_W'(lfsr_step(MAX_LFSR_W'(chain[gi]), MAX_LFSR_W'(TAP_MASK)));
    end

    assign state_o = chain[STEP];

endmodule

// File: rtl/lfsr_rand_gen.sv
// Pseudo-random word source built on an LFSR, delivered over a valid/ready handshake.
// A reseed with a zero seed_in falls back to SEED so the register can never sit at zero.
module lfsr_rand_gen
    import gpu_rand_pkg::*;
#(
    parameter int                LFSR_W   = 48,
    parameter int                OUT_W    = 12,
    parameter int                STEP     = 12,
    parameter logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(GPU_RAND_MASK48),
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(GPU_RAND_SEED48)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  rand_num,
    output logic              seed_fixed
);

    localparam int CNT_W = $clog2(OUT_W) + 1;

    logic [LFSR_W-1:0] state_q, state_d;
    logic [LFSR_W-1:0] stepped;
    logic [CNT_W-1:0]  fresh_q, fresh_d;
    logic [CNT_W:0]    cnt_sum;
    logic [OUT_W-1:0]  rand_q, rand_d;
    logic              valid_q, valid_d;
    logic              fixed_q, fixed_d;
    logic              stall;
    logic              accept;

    lfsr_unroll #(
        .LFSR_W  (LFSR_W),
        .STEP    (STEP),
        .TAP_MASK(TAP_MASK)
    ) u_unroll (
        .state_i(state_q),
        .state_o(stepped)
    );

    assign stall   = valid_q & ~out_ready;
    assign accept  = valid_q & out_ready;
    assign cnt_sum = {1'b0, fresh_q} + (CNT_W+1)'(STEP);

    always_comb begin
        state_d = state_q;
        fresh_d = fresh_q;
        rand_d  = rand_q;
        valid_d = valid_q;
        fixed_d = 1'b0;
        if (seed_load) begin
            // A reload discards the partial word and any pending output, but keeps rand_num.
            state_d = (seed_in == '0) ? SEED : seed_in;
            fresh_d = '0;
            valid_d = 1'b0;
            fixed_d = (seed_in == '0);
        end else begin
            if (accept) begin
                valid_d = 1'b0;
            end
            if (enable && !stall) begin
                state_d = stepped;
                if (cnt_sum >= (CNT_W+1)'(OUT_W)) begin
                    rand_d  = stepped[OUT_W-1:0];
                    valid_d = 1'b1;
                    fresh_d = '0;
                end else begin
                    fresh_d = cnt_sum[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
            fresh_q <= '0;
            rand_q  <= '0;
            valid_q <= 1'b0;
            fixed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fresh_q <= fresh_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
            fixed_q <= fixed_d;
        end
    end

    assign out_valid  = valid_q;
    assign rand_num   = rand_q;
    assign seed_fixed = fixed_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: default 48-bit build, a 4-bit maximal-length build
// and a single-shift build used for the asynchronous reset and latency checks.
module tb_lfsr_rand_gen;

    localparam logic [47:0] SEED48 = 48'h1234_5678_9ABC;
    localparam logic [47:0] ALT48  = 48'hDEAD_BEEF_0001;

    logic clk;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Default build.
    logic        rst_a, en_a, sl_a, rdy_a, v_a, f_a;
    logic [47:0] seed_a;
    logic [11:0] r_a;

    // 4-bit build.
    logic        rst_b, en_b, sl_b, rdy_b, v_b, f_b;
    logic [3:0]  seed_b, r_b;

    // Single-shift build.
    logic        rst_c, en_c, sl_c, rdy_c, v_c, f_c;
    logic [47:0] seed_c;
    logic [11:0] r_c;

    lfsr_rand_gen u_dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .seed_load(sl_a), .seed_in(seed_a),
        .out_ready(rdy_a), .out_valid(v_a), .rand_num(r_a), .seed_fixed(f_a)
    );

    lfsr_rand_gen #(
        .LFSR_W(4), .OUT_W(4), .STEP(1), .TAP_MASK(4'hC), .SEED(4'h1)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .seed_load(sl_b), .seed_in(seed_b),
        .out_ready(rdy_b), .out_valid(v_b), .rand_num(r_b), .seed_fixed(f_b)
    );

    lfsr_rand_gen #(.STEP(1)) u_dut_c (
        .clk(clk), .reset(rst_c), .enable(en_c), .seed_load(sl_c), .seed_in(seed_c),
        .out_ready(rdy_c), .out_valid(v_c), .rand_num(r_c), .seed_fixed(f_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference x^48 register: feedback from bits 47, 46, 21 and 20, shifted in at bit 0.
    function automatic logic [47:0] m_adv(input logic [47:0] s, input int n);
        logic fb;
        for (int i = 0; i < n; i++) begin
            fb = s[47] ^ s[46] ^ s[21] ^ s[20];
            s  = {s[46:0], fb};
        end
        return s;
    endfunction

    // 4-bit register x^4+x^3+1 from 4'h1, sampled every 4th shift.
    logic [3:0] seq4 [0:14] = '{4'h3, 4'h5, 4'hE, 4'h2, 4'h6, 4'hB, 4'hC, 4'h4,
                                4'hD, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF, 4'h1};

    logic [47:0] m;
    logic [11:0] first_w [0:2];
    logic [11:0] held;
    int          t;

    initial begin
        rst_a = 1; en_a = 0; sl_a = 0; rdy_a = 0; seed_a = '0;
        rst_b = 1; en_b = 0; sl_b = 0; rdy_b = 0; seed_b = '0;
        rst_c = 1; en_c = 0; sl_c = 0; rdy_c = 0; seed_c = '0;

        m = SEED48;
        for (int i = 0; i < 3; i++) begin
            m = m_adv(m, 12);
            first_w[i] = m[11:0];
        end

        // Reset state and first words of the default build.
        tick();
        chk("a_rst_valid", 64'(v_a), 64'd0);
        chk("a_rst_rand", 64'(r_a), 64'd0);
        chk("a_rst_fixed", 64'(f_a), 64'd0);
        rst_a = 0;
        tick();
        chk("a_idle_valid", 64'(v_a), 64'd0);
        en_a = 1; rdy_a = 1;
        m = SEED48;
        for (int i = 0; i < 4; i++) begin
            tick();
            m = m_adv(m, 12);
            chk("a_valid", 64'(v_a), 64'd1);
            chk("a_word", 64'(r_a), 64'(m[11:0]));
        end

        // Backpressure: word and generator frozen, nothing lost afterwards.
        held  = r_a;
        rdy_a = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_stall_valid", 64'(v_a), 64'd1);
            chk("a_stall_word", 64'(r_a), 64'(held));
        end
        rdy_a = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            m = m_adv(m, 12);
            chk("a_resume_word", 64'(r_a), 64'(m[11:0]));
        end

        // Zero reseed falls back to SEED and replays the post-reset stream.
        held = r_a;
        sl_a = 1; seed_a = '0;
        tick();
        chk("a_zero_fixed", 64'(f_a), 64'd1);
        chk("a_zero_valid", 64'(v_a), 64'd0);
        chk("a_zero_held", 64'(r_a), 64'(held));
        sl_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) chk("a_fixed_pulse", 64'(f_a), 64'd0);
            chk("a_replay_valid", 64'(v_a), 64'd1);
            chk("a_replay_word", 64'(r_a), 64'(first_w[i]));
        end

        // Reseed during a stall.
        rdy_a = 0;
        tick();
        chk("a_pre_seed_word", 64'(r_a), 64'(first_w[2]));
        sl_a = 1; seed_a = ALT48;
        tick();
        chk("a_seed_valid", 64'(v_a), 64'd0);
        chk("a_seed_fixed", 64'(f_a), 64'd0);
        sl_a = 0; rdy_a = 1;
        m = ALT48;
        for (int i = 0; i < 3; i++) begin
            tick();
            m = m_adv(m, 12);
            chk("a_alt_valid", 64'(v_a), 64'd1);
            chk("a_alt_word", 64'(r_a), 64'(m[11:0]));
        end

        // Enable low: pending word persists until accepted.
        en_a = 0; rdy_a = 0;
        tick();
        chk("a_hold_valid", 64'(v_a), 64'd1);
        chk("a_hold_word", 64'(r_a), 64'(m[11:0]));
        rdy_a = 1;
        tick();
        chk("a_drain_valid", 64'(v_a), 64'd0);

        // 4-bit build: one word every 4 cycles, 15-word permutation, then repeat.
        rst_b = 0; en_b = 1; rdy_b = 1;
        for (int k = 0; k < 17; k++) begin
            t = 0;
            do begin
                tick();
                t++;
            end while (!v_b && t < 8);
            chk("b_gap", 64'(t), 64'd4);
            chk("b_word", 64'(r_b), 64'(seq4[k % 15]));
        end

        // Single-shift build: latency, then asynchronous reset with fresh_cnt at 7.
        rst_c = 0; en_c = 1; rdy_c = 1;
        for (int i = 0; i < 11; i++) tick();
        chk("c_early_valid", 64'(v_c), 64'd0);
        tick();
        chk("c_first_valid", 64'(v_c), 64'd1);
        chk("c_first_word", 64'(r_c), 64'(first_w[0]));
        for (int i = 0; i < 7; i++) tick();
        chk("c_mid_valid", 64'(v_c), 64'd0);
        chk("c_mid_word", 64'(r_c), 64'(first_w[0]));
        #3;
        rst_c = 1;
        #1;
        chk("c_async_rand", 64'(r_c), 64'd0);
        chk("c_async_valid", 64'(v_c), 64'd0);
        tick();
        rst_c = 0;
        for (int i = 0; i < 11; i++) tick();
        chk("c_restart_early", 64'(v_c), 64'd0);
        tick();
        chk("c_restart_valid", 64'(v_c), 64'd1);
        chk("c_restart_word", 64'(r_c), 64'(first_w[0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
